// File: rtl/bus_rr_arbiter_if.sv
// Bundle of requester-side and slave-side signals around bus_rr_arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface bus_rr_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4
);
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0]        m_valid;
  logic [NUM_MASTERS*ADDR_W-1:0] m_addr;
  logic [NUM_MASTERS*DATA_W-1:0] m_wdata;
  logic [NUM_MASTERS-1:0]        m_ready;
  logic [DATA_W-1:0]             m_rdata;
  logic                          m_err;
  logic                          s_valid;
  logic [ADDR_W-1:0]             s_addr;
  logic [DATA_W-1:0]             s_wdata;
  logic [DATA_W-1:0]             s_rdata;
  logic                          s_ready;
  logic [GW-1:0]                 grant;
  logic                          busy;

  modport slave (
    input  m_valid, m_addr, m_wdata, s_rdata, s_ready,
    output m_ready, m_rdata, m_err, s_valid, s_addr, s_wdata, grant, busy
  );

  modport master (
    output m_valid, m_addr, m_wdata, s_rdata, s_ready,
    input  m_ready, m_rdata, m_err, s_valid, s_addr, s_wdata, grant, busy
  );
endinterface

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready slave among NUM_MASTERS requesters.
// Define BUS_ARB_TIMEOUT_EN to abort slave transactions that stay in BUSY for TIMEOUT cycles.
module bus_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4
`ifdef BUS_ARB_TIMEOUT_EN
  , parameter int TIMEOUT   = 15
`endif
) (
  input logic             clock,
  input logic             reset_n,
  bus_rr_arbiter_if.slave bus
);
  localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [GW-1:0]           r_last;
  logic [GW-1:0]           r_grant;
  logic [ADDR_W-1:0]       r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic [DATA_W-1:0]       r_rdata;
  logic [GW-1:0]           w_pick;
  logic [GW-1:0]           w_idx;
  logic                    w_found;
  logic                    w_timeout;
  logic [ADDR_W-1:0]       w_addr;
  logic [DATA_W-1:0]       w_wdata;
  logic [NUM_MASTERS-1:0]  w_ready;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;

  // The edge that would bring the count to TIMEOUT is the abort edge.
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Descending scan so the nearest requester after r_last is written last and wins.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    w_pick  = '0;
    w_idx   = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      w_idx = GW'((int'(r_last) + k) % NUM_MASTERS);
      if (bus.m_valid[w_idx]) w_pick = w_idx;
    end
    w_found = |bus.m_valid;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_pick == GW'(i)) begin
        w_addr  = bus.m_addr[i*ADDR_W +: ADDR_W];
        w_wdata = bus.m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = BUSY;
      BUSY:    if (bus.s_ready || w_timeout) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_last  <= GW'(NUM_MASTERS - 1);
      r_grant <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
`ifdef BUS_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        BUSY: begin
          if (bus.s_ready) begin
            r_rdata <= bus.s_rdata;
            r_last  <= r_grant;
`ifdef BUS_ARB_TIMEOUT_EN
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_last  <= r_grant;
            r_err   <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CW'(1);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_ready = '0;
    if (r_state == RESP) w_ready[r_grant] = 1'b1;
  end

  assign bus.s_valid = (r_state == BUSY);
  assign bus.s_addr  = r_addr;
  assign bus.s_wdata = r_wdata;
  assign bus.m_ready = w_ready;
  assign bus.m_rdata = r_rdata;
  assign bus.grant   = r_grant;
  assign bus.busy    = (r_state != IDLE);
`ifdef BUS_ARB_TIMEOUT_EN
  assign bus.m_err   = r_err & (r_state == RESP);
`else
  assign bus.m_err   = 1'b0;
`endif
endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter: a 2-master instance with a delay-programmable echo
// slave, and a 4-master instance with a combinational echo slave for wrap-around grants.
module tb_bus_rr_arbiter;
  logic clock;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  int   sl_cnt;
  int   sl_delay;
  logic sl_stuck;

  bus_rr_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(4), .DATA_W(4)) bus2 ();
  bus_rr_arbiter_if #(.NUM_MASTERS(4), .ADDR_W(4), .DATA_W(4)) bus4 ();

  bus_rr_arbiter #(.NUM_MASTERS(2), .ADDR_W(4), .DATA_W(4)) dut2 (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus2.slave)
  );

  bus_rr_arbiter #(.NUM_MASTERS(4), .ADDR_W(4), .DATA_W(4)) dut4 (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus4.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Echo slave for dut2: ready after sl_delay waiting cycles unless stuck.
  assign bus2.s_ready = bus2.s_valid && !sl_stuck && (sl_cnt >= sl_delay);
  assign bus2.s_rdata = bus2.s_wdata;
  always @(posedge clock) begin
    if (bus2.s_valid && !bus2.s_ready) sl_cnt <= sl_cnt + 1;
    else                               sl_cnt <= 0;
  end

  assign bus4.s_ready = bus4.s_valid;
  assign bus4.s_rdata = bus4.s_wdata;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus2.m_valid  = '0;
    bus2.m_addr   = '0;
    bus2.m_wdata  = '0;
    bus4.m_valid  = '0;
    bus4.m_addr   = '0;
    bus4.m_wdata  = '0;
    sl_delay      = 0;
    sl_stuck      = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({bus2.s_valid, bus2.s_addr, bus2.s_wdata} !== 9'h000) begin
      n_bad++;
      $display("FAIL reset_slave_side: got %h want 000", {bus2.s_valid, bus2.s_addr, bus2.s_wdata});
    end
    n_cmp++;
    if ({bus2.m_ready, bus2.m_rdata, bus2.m_err} !== 7'h00) begin
      n_bad++;
      $display("FAIL reset_master_side: got %h want 00", {bus2.m_ready, bus2.m_rdata, bus2.m_err});
    end
    n_cmp++;
    if ({bus2.grant, bus2.busy, bus4.grant, bus4.busy} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_grant_busy: got %b want 00000", {bus2.grant, bus2.busy, bus4.grant, bus4.busy});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus2.m_valid = 2'b01;
    bus2.m_addr  = 8'h0C;
    bus2.m_wdata = 8'h0C;
    tick();
    n_cmp++;
    if ({bus2.s_valid, bus2.s_addr, bus2.s_wdata, bus2.busy} !== {1'b1, 4'hC, 4'hC, 1'b1}) begin
      n_bad++;
      $display("FAIL single_cycle1: got v=%b a=%h w=%h busy=%b want v=1 a=c w=c busy=1",
               bus2.s_valid, bus2.s_addr, bus2.s_wdata, bus2.busy);
    end
    n_cmp++;
    if (bus2.m_ready !== 2'b00) begin
      n_bad++;
      $display("FAIL single_no_early_ready: got %b want 00", bus2.m_ready);
    end
    tick();
    n_cmp++;
    if ({bus2.m_ready, bus2.m_rdata, bus2.m_err, bus2.s_valid} !== {2'b01, 4'hC, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL single_cycle2: got rdy=%b d=%h err=%b sv=%b want rdy=01 d=c err=0 sv=0",
               bus2.m_ready, bus2.m_rdata, bus2.m_err, bus2.s_valid);
    end
    bus2.m_valid = 2'b00;
    tick();
    n_cmp++;
    if ({bus2.m_ready, bus2.busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL single_cycle3_idle: got rdy=%b busy=%b want 00 0", bus2.m_ready, bus2.busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ea [2];
    logic [3:0] ew [2];
    ea = '{4'h3, 4'hA};
    ew = '{4'h5, 4'h6};
    // Fresh reset so master 0 has priority again.
    reset_n = 1'b0;
    tick();
    reset_n      = 1'b1;
    bus2.m_valid = 2'b11;
    bus2.m_addr  = {4'hA, 4'h3};
    bus2.m_wdata = {4'h6, 4'h5};
    for (int t = 0; t < 4; t++) begin
      int g;
      g = t % 2;
      tick();
      n_cmp++;
      if ({bus2.grant, bus2.s_valid, bus2.s_addr, bus2.s_wdata} !== {g[0], 1'b1, ea[g], ew[g]}) begin
        n_bad++;
        $display("FAIL b2b_busy_%0d: got g=%b a=%h w=%h want g=%0d a=%h w=%h",
                 t, bus2.grant, bus2.s_addr, bus2.s_wdata, g, ea[g], ew[g]);
      end
      tick();
      n_cmp++;
      if ({bus2.m_ready, bus2.m_rdata} !== {((g == 0) ? 2'b01 : 2'b10), ew[g]}) begin
        n_bad++;
        $display("FAIL b2b_resp_%0d: got rdy=%b d=%h want master %0d d=%h",
                 t, bus2.m_ready, bus2.m_rdata, g, ew[g]);
      end
      tick();
      n_cmp++;
      if ({bus2.m_ready, bus2.busy} !== 3'b000) begin
        n_bad++;
        $display("FAIL b2b_idle_%0d: got rdy=%b busy=%b want 00 0", t, bus2.m_ready, bus2.busy);
      end
    end
    bus2.m_valid = 2'b00;
    tick();
  endtask

  task automatic test_slow_slave();
    // last is master 1 here, so master 0 wins; ready comes after 4 waiting cycles.
    sl_delay     = 4;
    bus2.m_valid = 2'b01;
    bus2.m_addr  = 8'h07;
    bus2.m_wdata = 8'h09;
    tick();
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({bus2.s_valid, bus2.s_addr, bus2.s_wdata, bus2.m_ready} !== {1'b1, 4'h7, 4'h9, 2'b00}) begin
        n_bad++;
        $display("FAIL slow_stable_%0d: got v=%b a=%h w=%h rdy=%b want v=1 a=7 w=9 rdy=00",
                 k, bus2.s_valid, bus2.s_addr, bus2.s_wdata, bus2.m_ready);
      end
      if (k == 1) bus2.m_valid = 2'b00;
      tick();
    end
    n_cmp++;
    if ({bus2.m_ready, bus2.m_rdata} !== {2'b01, 4'h9}) begin
      n_bad++;
      $display("FAIL slow_resp: got rdy=%b d=%h want 01 9", bus2.m_ready, bus2.m_rdata);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++;
      if ({bus2.m_ready, bus2.busy} !== 3'b000) begin
        n_bad++;
        $display("FAIL slow_single_pulse_%0d: got rdy=%b busy=%b want 00 0", k, bus2.m_ready, bus2.busy);
      end
    end
    sl_delay = 0;
  endtask

  task automatic test_wrap4();
    logic [3:0] vec [6];
    int         exp_g [6];
    vec   = '{4'b1001, 4'b1001, 4'b0110, 4'b0110, 4'b1111, 4'b1111};
    exp_g = '{0, 3, 1, 2, 3, 0};
    bus4.m_addr  = {4'hB, 4'hA, 4'h9, 4'h8};
    bus4.m_wdata = {4'h4, 4'h3, 4'h2, 4'h1};
    for (int r = 0; r < 6; r++) begin
      logic [1:0] eg;
      logic [3:0] er;
      logic [3:0] ea;
      logic [3:0] ed;
      eg = 2'(exp_g[r]);
      er = 4'b0001 << exp_g[r];
      ea = 4'h8 + 4'(exp_g[r]);
      ed = 4'h1 + 4'(exp_g[r]);
      bus4.m_valid = vec[r];
      tick();
      n_cmp++;
      if ({bus4.grant, bus4.s_valid, bus4.s_addr} !== {eg, 1'b1, ea}) begin
        n_bad++;
        $display("FAIL wrap4_grant_%0d: got g=%0d v=%b a=%h want g=%0d v=1 a=%h",
                 r, bus4.grant, bus4.s_valid, bus4.s_addr, eg, ea);
      end
      tick();
      n_cmp++;
      if ({bus4.m_ready, bus4.m_rdata} !== {er, ed}) begin
        n_bad++;
        $display("FAIL wrap4_resp_%0d: got rdy=%b d=%h want rdy=%b d=%h",
                 r, bus4.m_ready, bus4.m_rdata, er, ed);
      end
      bus4.m_valid = 4'b0000;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    sl_delay     = 4;
    bus2.m_valid = 2'b10;
    bus2.m_addr  = 8'hD0;
    bus2.m_wdata = 8'hE0;
    tick();
    n_cmp++;
    if ({bus2.busy, bus2.s_valid, bus2.grant} !== 3'b111) begin
      n_bad++;
      $display("FAIL rstmid_busy: got busy=%b v=%b g=%b want 1 1 1", bus2.busy, bus2.s_valid, bus2.grant);
    end
    reset_n      = 1'b0;
    bus2.m_valid = 2'b00;
    tick();
    reset_n = 1'b1;
    n_cmp++;
    if ({bus2.busy, bus2.s_valid, bus2.grant, bus2.m_ready} !== 5'b00000) begin
      n_bad++;
      $display("FAIL rstmid_idle: got busy=%b v=%b g=%b rdy=%b want 0 0 0 00",
               bus2.busy, bus2.s_valid, bus2.grant, bus2.m_ready);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if ({bus2.m_ready, bus2.busy} !== 3'b000) begin
        n_bad++;
        $display("FAIL rstmid_no_pulse_%0d: got rdy=%b busy=%b want 00 0", k, bus2.m_ready, bus2.busy);
      end
    end
    sl_delay = 0;
  endtask

`ifdef BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    // Ready lands exactly on the 15th BUSY edge: normal completion wins.
    sl_delay     = 14;
    bus2.m_valid = 2'b01;
    bus2.m_addr  = 8'h05;
    bus2.m_wdata = 8'h0B;
    tick();
    for (int k = 0; k < 15; k++) begin
      n_cmp++;
      if ({bus2.s_valid, bus2.m_ready} !== 3'b100) begin
        n_bad++;
        $display("FAIL tmo_race_busy_%0d: got v=%b rdy=%b want 1 00", k, bus2.s_valid, bus2.m_ready);
      end
      tick();
    end
    n_cmp++;
    if ({bus2.m_ready, bus2.m_err, bus2.m_rdata} !== {2'b01, 1'b0, 4'hB}) begin
      n_bad++;
      $display("FAIL tmo_race_resp: got rdy=%b err=%b d=%h want 01 0 b", bus2.m_ready, bus2.m_err, bus2.m_rdata);
    end
    bus2.m_valid = 2'b00;
    tick();
    // Slave never answers: abort after 15 BUSY cycles with zeroed data.
    sl_stuck     = 1'b1;
    bus2.m_valid = 2'b10;
    bus2.m_addr  = 8'hE0;
    bus2.m_wdata = 8'h70;
    tick();
    for (int k = 0; k < 15; k++) begin
      n_cmp++;
      if ({bus2.s_valid, bus2.m_ready} !== 3'b100) begin
        n_bad++;
        $display("FAIL tmo_stuck_busy_%0d: got v=%b rdy=%b want 1 00", k, bus2.s_valid, bus2.m_ready);
      end
      tick();
    end
    n_cmp++;
    if ({bus2.m_ready, bus2.m_err, bus2.m_rdata, bus2.s_valid} !== {2'b10, 1'b1, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL tmo_stuck_resp: got rdy=%b err=%b d=%h v=%b want 10 1 0 0",
               bus2.m_ready, bus2.m_err, bus2.m_rdata, bus2.s_valid);
    end
    bus2.m_valid = 2'b00;
    sl_stuck     = 1'b0;
    sl_delay     = 0;
    tick();
    n_cmp++;
    if ({bus2.m_ready, bus2.m_err, bus2.busy} !== 4'b0000) begin
      n_bad++;
      $display("FAIL tmo_after: got rdy=%b err=%b busy=%b want 00 0 0", bus2.m_ready, bus2.m_err, bus2.busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_slow_slave();
    test_wrap4();
    test_reset_mid();
`ifdef BUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at %0t, want finish before 100000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
